// File: rtl/tk1_exec_guard.sv
`default_nettype none
// ============================================================================
// Module   : tk1_exec_guard
// Brief    : Execute-protection guard. Watches CPU accesses for RAM
//            out-of-range, FW-RAM instruction fetches and fetches from
//            up to NUM_REGIONS lockable address regions. Raises a sticky
//            force_trap, records the first violation and counts violations.
//            Optional macro TK1_EXEC_GUARD_BLINK_EN makes trap_led blink
//            from a BLINK_W-bit counter instead of following force_trap.
// Revision : 1.0 - initial release
// ============================================================================
module tk1_exec_guard #(
    parameter int NUM_REGIONS = 4,
    parameter int BLINK_W     = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        force_trap,
    output logic        trap_led
);

    localparam logic [7:0]  c_ADDR_CTRL      = 8'h00;
    localparam logic [7:0]  c_ADDR_STATUS    = 8'h01;
    localparam logic [7:0]  c_ADDR_VIOL_ADDR = 8'h02;
    localparam logic [7:0]  c_ADDR_VIOL_CNT  = 8'h03;
    localparam logic [31:0] c_FW_FIRST       = 32'hD000_0000;
    localparam logic [31:0] c_FW_LAST        = 32'hD000_07FF;
    localparam logic [3:0]  c_CAUSE_RAM      = 4'd1;
    localparam logic [3:0]  c_CAUSE_FW       = 4'd2;

    // Elaboration-time parameter sanity checks.
    if (NUM_REGIONS < 1 || NUM_REGIONS > 8) begin : g_bad_num_regions
        $error("tk1_exec_guard: NUM_REGIONS must be 1..8");
    end
    if (BLINK_W < 1) begin : g_bad_blink_w
        $error("tk1_exec_guard: BLINK_W must be at least 1");
    end

    logic [NUM_REGIONS-1:0] r_ctrl;
    logic [31:0]            r_first [NUM_REGIONS];
    logic [31:0]            r_last  [NUM_REGIONS];
    logic [3:0]             r_cause;
    logic [31:0]            r_viol_addr;
    logic [7:0]             r_viol_cnt;
    logic                   r_force_trap;

    logic                   w_wr;
    logic                   w_rd;
    logic [NUM_REGIONS-1:0] w_region_hit;
    logic                   w_viol;
    logic [3:0]             w_cause;

    assign w_wr  = cs & we;
    assign w_rd  = cs & ~we;
    assign ready = cs;

    // An inverted region (FIRST > LAST) can never satisfy both compares.
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        assign w_region_hit[gi] = cpu_instr & r_ctrl[gi] &
                                  (cpu_addr >= r_first[gi]) &
                                  (cpu_addr <= r_last[gi]);
    end

    // Classify the current access; region loop runs downward so the lowest index wins.
    always_comb begin
        w_viol  = 1'b0;
        w_cause = 4'd0;
        if (cpu_valid) begin
            if (cpu_addr[31:30] == 2'b01 && |cpu_addr[29:17]) begin
                w_viol  = 1'b1;
                w_cause = c_CAUSE_RAM;
            end else if (cpu_instr && cpu_addr >= c_FW_FIRST && cpu_addr <= c_FW_LAST) begin
                w_viol  = 1'b1;
                w_cause = c_CAUSE_FW;
            end else begin
                for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
                    if (w_region_hit[i]) begin
                        w_viol  = 1'b1;
                        w_cause = 4'(3 + i);
                    end
                end
            end
        end
    end

    // Register read mux; drives 0 whenever the bus is not reading.
    always_comb begin
        read_data = 32'd0;
        if (w_rd) begin
            case (address)
                c_ADDR_CTRL:      read_data = 32'(r_ctrl);
                c_ADDR_STATUS:    read_data = {24'd0, r_cause, 3'b000, r_force_trap};
                c_ADDR_VIOL_ADDR: read_data = r_viol_addr;
                c_ADDR_VIOL_CNT:  read_data = {24'd0, r_viol_cnt};
                default: begin
                    for (int i = 0; i < NUM_REGIONS; i++) begin
                        if (address == 8'(16 + 2 * i)) read_data = r_first[i];
                        if (address == 8'(17 + 2 * i)) read_data = r_last[i];
                    end
                end
            endcase
        end
    end

    // Configuration registers; region bounds lock once their enable is set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_first[i] <= 32'd0;
                r_last[i]  <= 32'd0;
            end
        end else if (w_wr) begin
            if (address == c_ADDR_CTRL) begin
                r_ctrl <= r_ctrl | write_data[NUM_REGIONS-1:0];
            end
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (!r_ctrl[i]) begin
                    if (address == 8'(16 + 2 * i)) r_first[i] <= write_data;
                    if (address == 8'(17 + 2 * i)) r_last[i]  <= write_data;
                end
            end
        end
    end

    // Sticky trap, first-violation capture and saturating count (clear beats increment).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_force_trap <= 1'b0;
            r_cause      <= 4'd0;
            r_viol_addr  <= 32'd0;
            r_viol_cnt   <= 8'd0;
        end else begin
            if (w_viol && !r_force_trap) begin
                r_cause     <= w_cause;
                r_viol_addr <= cpu_addr;
            end
            r_force_trap <= r_force_trap | w_viol;
            if (w_wr && address == c_ADDR_VIOL_CNT) begin
                r_viol_cnt <= 8'd0;
            end else if (w_viol && r_viol_cnt != 8'hFF) begin
                r_viol_cnt <= r_viol_cnt + 8'd1;
            end
        end
    end

    assign force_trap = r_force_trap;

`ifdef TK1_EXEC_GUARD_BLINK_EN
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_led;

    // Free-running blink counter while trapped; LED flips on every wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
        end else if (r_force_trap) begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (&r_blink_cnt) r_led <= ~r_led;
        end
    end

    assign trap_led = r_led;
`else
    assign trap_led = r_force_trap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tk1_exec_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_tk1_exec_guard
// Brief    : Self-checking bench for tk1_exec_guard; directed scenarios plus
//            randomized traffic compared against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tk1_exec_guard;

    localparam int TB_REGIONS = 4;
    localparam int TB_BLINK_W = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_valid = 1'b0;
    logic        cpu_instr = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  address = 8'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic        force_trap;
    logic        trap_led;

    int errors = 0;
    int checks = 0;

    tk1_exec_guard #(
        .NUM_REGIONS (TB_REGIONS),
        .BLINK_W     (TB_BLINK_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_valid  (cpu_valid),
        .cpu_instr  (cpu_instr),
        .cpu_addr   (cpu_addr),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .force_trap (force_trap),
        .trap_led   (trap_led)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit [TB_REGIONS-1:0] m_ctrl;
    logic [31:0]         m_first [TB_REGIONS];
    logic [31:0]         m_last  [TB_REGIONS];
    bit                  m_trap;
    int                  m_cause;
    logic [31:0]         m_vaddr;
    int                  m_cnt;
    int                  m_tcnt;   // clock edges seen while already trapped

    function automatic int model_cause(input bit v, input bit ins, input logic [31:0] a);
        if (!v) return 0;
        if (a >= 32'h4000_0000 && a < 32'h8000_0000 && (a - 32'h4000_0000) >= 32'h0002_0000)
            return 1;
        if (ins && a >= 32'hD000_0000 && a <= 32'hD000_0000 + 32'h7FF)
            return 2;
        for (int i = 0; i < TB_REGIONS; i++)
            if (ins && m_ctrl[i] && m_first[i] <= a && a <= m_last[i]) return 3 + i;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] adr);
        int idx;
        if (adr == 8'h00) return 32'(m_ctrl);
        if (adr == 8'h01) return {24'd0, 4'(m_cause), 3'b000, m_trap};
        if (adr == 8'h02) return m_vaddr;
        if (adr == 8'h03) return 32'(m_cnt);
        if (adr >= 8'h10 && adr < 8'(16 + 2 * TB_REGIONS)) begin
            idx = (int'(adr) - 16) / 2;
            return adr[0] ? m_last[idx] : m_first[idx];
        end
        return 32'd0;
    endfunction

    function automatic bit exp_led();
`ifdef TK1_EXEC_GUARD_BLINK_EN
        return m_trap ? bit'((m_tcnt / (1 << TB_BLINK_W)) % 2) : 1'b0;
`else
        return m_trap;
`endif
    endfunction

    task automatic model_update(input bit v, input bit ins, input logic [31:0] a,
                                input bit bcs, input bit bwe, input logic [7:0] badr,
                                input logic [31:0] bwd);
        int  c;
        bit  was_trapped;
        bit  clr;
        int  idx;
        if (!reset_n) begin
            m_ctrl = '0; m_trap = 0; m_cause = 0; m_vaddr = 0; m_cnt = 0; m_tcnt = 0;
            for (int i = 0; i < TB_REGIONS; i++) begin m_first[i] = 0; m_last[i] = 0; end
            return;
        end
        c = model_cause(v, ins, a);
        was_trapped = m_trap;
        clr = bcs && bwe && badr == 8'h03;
        if (bcs && bwe) begin
            if (badr == 8'h00) m_ctrl = m_ctrl | bwd[TB_REGIONS-1:0];
            if (badr >= 8'h10 && badr < 8'(16 + 2 * TB_REGIONS)) begin
                idx = (int'(badr) - 16) / 2;
                if (!m_ctrl[idx]) begin
                    if (badr[0]) m_last[idx] = bwd; else m_first[idx] = bwd;
                end
            end
        end
        if (c != 0) begin
            if (!m_trap) begin m_cause = c; m_vaddr = a; end
            m_trap = 1;
            if (!clr && m_cnt < 255) m_cnt++;
        end
        if (clr) m_cnt = 0;
        if (was_trapped) m_tcnt++;
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic step(input bit v, input bit ins, input logic [31:0] a,
                        input bit bcs, input bit bwe, input logic [7:0] badr,
                        input logic [31:0] bwd);
        cpu_valid = v; cpu_instr = ins; cpu_addr = a;
        cs = bcs; we = bwe; address = badr; write_data = bwd;
        @(posedge clk);
        model_update(v, ins, a, bcs, bwe, badr, bwd);
        #1;
        cpu_valid = 0; cs = 0; we = 0;
    endtask

    task automatic idle();
        step(0, 0, 32'd0, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic access(input bit ins, input logic [31:0] a);
        step(1, ins, a, 0, 0, 8'd0, 32'd0);
    endtask

    task automatic bus_write(input logic [7:0] adr, input logic [31:0] d);
        step(0, 0, 32'd0, 1, 1, adr, d);
    endtask

    // Present a read combinationally; caller compares read_data, then calls idle().
    task automatic rd(input logic [7:0] adr);
        cpu_valid = 0; cs = 1; we = 0; address = adr;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle();
        reset_n = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] regs [5];
        regs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10};
        do_reset();
        checks++;
        if (force_trap !== 1'b0 || trap_led !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: force_trap=%b trap_led=%b expected 0 0", force_trap, trap_led);
        end
        foreach (regs[k]) begin
            rd(regs[k]);
            checks++;
            if (read_data !== 32'd0 || ready !== 1'b1) begin
                errors++; $display("FAIL reset_reg_%h: read=%h ready=%b expected 0 1", regs[k], read_data, ready);
            end
            idle();
        end
        checks++;
        if (read_data !== 32'd0 || ready !== 1'b0) begin
            errors++; $display("FAIL idle_bus: read=%h ready=%b expected 0 0", read_data, ready);
        end
    endtask

    task automatic test_fw_exec();
        do_reset();
        access(1, 32'hD000_0100);
        checks++;
        if (force_trap !== 1'b1) begin
            errors++; $display("FAIL fw_trap: force_trap=%b expected 1", force_trap);
        end
        rd(8'h01); checks++;
        if (read_data !== 32'h21) begin errors++; $display("FAIL fw_status: got %h expected 00000021", read_data); end
        idle();
        rd(8'h02); checks++;
        if (read_data !== 32'hD000_0100) begin errors++; $display("FAIL fw_viol_addr: got %h expected d0000100", read_data); end
        idle();
    endtask

    task automatic test_ram_oor();
        do_reset();
        access(0, 32'h4001_FFFF);   // last in-range RAM word: legal
        checks++;
        if (force_trap !== 1'b0) begin errors++; $display("FAIL ram_edge: force_trap=%b expected 0", force_trap); end
        access(0, 32'h4002_0000);
        access(1, 32'hD000_0000);
        rd(8'h01); checks++;
        if (read_data !== 32'h11) begin errors++; $display("FAIL ram_status: got %h expected 00000011", read_data); end
        idle();
        rd(8'h02); checks++;
        if (read_data !== 32'h4002_0000) begin errors++; $display("FAIL ram_viol_addr: got %h expected 40020000", read_data); end
        idle();
        rd(8'h03); checks++;
        if (read_data !== 32'd2) begin errors++; $display("FAIL ram_cnt: got %h expected 00000002", read_data); end
        idle();
    endtask

    task automatic test_region();
        do_reset();
        bus_write(8'h12, 32'h4000_1000);
        bus_write(8'h13, 32'h4000_1FFF);
        bus_write(8'h00, 32'h2);
        access(0, 32'h4000_1000);
        access(1, 32'h4000_2000);
        access(1, 32'h4000_0FFF);
        checks++;
        if (force_trap !== 1'b0) begin errors++; $display("FAIL region_no_trap: force_trap=%b expected 0", force_trap); end
        access(1, 32'h4000_1FFF);
        checks++;
        if (force_trap !== 1'b1) begin errors++; $display("FAIL region_trap: force_trap=%b expected 1", force_trap); end
        rd(8'h01); checks++;
        if (read_data !== 32'h41) begin errors++; $display("FAIL region_status: got %h expected 00000041", read_data); end
        idle();
        bus_write(8'h12, 32'h0);
        rd(8'h12); checks++;
        if (read_data !== 32'h4000_1000) begin errors++; $display("FAIL region_lock: got %h expected 40001000", read_data); end
        idle();
    endtask

    task automatic test_empty_region();
        do_reset();
        bus_write(8'h10, 32'h4000_0010);
        bus_write(8'h11, 32'h4000_000F);
        bus_write(8'h00, 32'h1);
        access(1, 32'h4000_0010);
        access(1, 32'h4000_000F);
        checks++;
        if (force_trap !== 1'b0) begin errors++; $display("FAIL empty_region: force_trap=%b expected 0", force_trap); end
        bus_write(8'h00, 32'h0);
        rd(8'h00); checks++;
        if (read_data !== 32'h1) begin errors++; $display("FAIL ctrl_sticky: got %h expected 00000001", read_data); end
        idle();
        bus_write(8'h00, 32'hFFFF_FFF0);   // bits above NUM_REGIONS do not exist
        rd(8'h00); checks++;
        if (read_data !== 32'h1) begin errors++; $display("FAIL ctrl_high_bits: got %h expected 00000001", read_data); end
        idle();
        bus_write(8'h18, 32'hDEAD_BEEF);
        rd(8'h18); checks++;
        if (read_data !== 32'd0) begin errors++; $display("FAIL unmapped: got %h expected 00000000", read_data); end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus_write(8'h14, 32'h0000_1000);
        bus_write(8'h15, 32'h0000_1FFF);
        step(1, 1, 32'h0000_1800, 1, 1, 8'h00, 32'h4);   // enable and fetch together
        checks++;
        if (force_trap !== 1'b0) begin errors++; $display("FAIL pre_write_check: force_trap=%b expected 0", force_trap); end
        access(1, 32'h0000_1800);
        rd(8'h01); checks++;
        if (read_data !== 32'h51) begin errors++; $display("FAIL region2_status: got %h expected 00000051", read_data); end
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int n = 0; n < 300; n++) access(0, 32'h7FFF_0000);
        rd(8'h03); checks++;
        if (read_data !== 32'hFF) begin errors++; $display("FAIL cnt_saturate: got %h expected 000000ff", read_data); end
        idle();
        step(1, 0, 32'h7FFF_0000, 1, 1, 8'h03, 32'h5A);
        rd(8'h03); checks++;
        if (read_data !== 32'h0) begin errors++; $display("FAIL cnt_clear_wins: got %h expected 00000000", read_data); end
        idle();
    endtask

    task automatic test_blink();
        do_reset();
        access(1, 32'hD000_0000);
        for (int n = 0; n < 40; n++) begin
            idle();
            checks++;
            if (trap_led !== exp_led() || force_trap !== 1'b1) begin
                errors++; $display("FAIL blink_%0d: led=%b trap=%b expected %b 1", n, trap_led, force_trap, exp_led());
            end
        end
        reset_n = 0;
        step(1, 1, 32'hD000_0000, 1, 1, 8'h00, 32'hF);   // reset beats violation and write
        reset_n = 1;
        checks++;
        if (force_trap !== 1'b0 || trap_led !== 1'b0) begin
            errors++; $display("FAIL blink_reset: trap=%b led=%b expected 0 0", force_trap, trap_led);
        end
        rd(8'h00); checks++;
        if (read_data !== 32'd0) begin errors++; $display("FAIL reset_beats_write: got %h expected 00000000", read_data); end
        idle();
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 32'h4002_0000;
            1: return 32'h4001_FFFF;
            2: return 32'hD000_0000 + 32'($urandom_range(0, 32'h7FF));
            3: return 32'hD000_0800;
            4: return 32'hCFFF_FFFF;
            5: return 32'h4000_0000 + 32'($urandom_range(0, 32'h3000));
            6: return 32'h4000_0000 + 32'($urandom_range(0, 32'h1_FFFF));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        bit          v, ins, bwe;
        logic [31:0] a, d;
        logic [7:0]  adr;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 160 == 159) reset_n = 0;
            v   = ($urandom_range(0, 9) < 3);
            ins = $urandom_range(0, 1);
            a   = pick_addr();
            bwe = ($urandom_range(0, 3) == 0);
            adr = 8'($urandom_range(0, 9) < 2 ? $urandom_range(0, 3) : $urandom_range(16, 25));
            d   = (adr == 8'h00) ? 32'($urandom_range(0, 15)) : 32'h4000_0000 + 32'($urandom_range(0, 32'h3000));
            if (adr == 8'h00 && $urandom_range(0, 3) != 0) d = 32'h0;
            cpu_valid = v; cpu_instr = ins; cpu_addr = a;
            cs = 1; we = bwe; address = adr; write_data = d;
            #1;
            if (!bwe) begin
                checks++;
                if (read_data !== model_read(adr)) begin
                    errors++; $display("FAIL rand_read_%h: got %h expected %h", adr, read_data, model_read(adr));
                end
            end
            step(v, ins, a, 1, bwe, adr, d);
            reset_n = 1;
            checks++;
            if (force_trap !== m_trap || trap_led !== exp_led()) begin
                errors++; $display("FAIL rand_trap_%0d: trap=%b led=%b expected %b %b", n, force_trap, trap_led, m_trap, exp_led());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fw_exec();
        test_ram_oor();
        test_region();
        test_empty_region();
        test_same_cycle();
        test_saturate();
        test_blink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
